mmcam_stage_sync: RTL

//  Parametrised synchronous matching-memory CAM stage for the data-driven pipeline.
//  MF=1 packets search DEPTH entries for a partner: same key, opposite LR.
//  Hit: one fired packet carrying both operands is emitted and the entry is freed.

---
 rtl/mmcam_stage_sync.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mmcam_stage_sync.sv
// ---------------------------------------------------------------------------
// mmcam_stage_sync : matching-memory CAM stage (pair operands by key/LR).
// Optional MMCAM_STATS_EN adds occupancy/high-watermark ports.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mmcam_stage_sync #(
  parameter int KEY_W  = 18,
  parameter int DATA_W = 18,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CP,
  input  logic              MR_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KEY_W-1:0]  in_key,
  input  logic              in_lr,
  input  logic              in_mf,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KEY_W-1:0]  out_key,
  output logic              out_fire,
  output logic [DATA_W-1:0] out_data_l,
  output logic [DATA_W-1:0] out_data_r,
  output logic              cam_wr,
  output logic              cam_del,
  output logic [ADDR_W-1:0] cam_addr,
  output logic              cam_full
`ifdef MMCAM_STATS_EN
  ,
  output logic [ADDR_W:0]   occ,
  output logic [ADDR_W:0]   occ_max
`endif
);

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_lr;
  logic [KEY_W-1:0]  ent_key  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  logic              hit;
  logic [ADDR_W-1:0] hit_idx;
  logic [ADDR_W-1:0] free_idx;
  logic [DEPTH-1:0]  valid_nxt;
  logic              out_free;
  logic              accept;
  logic              do_hit;
  logic              do_miss;
  logic              do_bypass;
  logic [DATA_W-1:0] hit_data;

  // Descending scan so the lowest matching / free index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid[i] && (ent_key[i] == in_key) && (ent_lr[i] != in_lr)) begin
        hit     = 1'b1;
        hit_idx = ADDR_W'(i);
      end
      if (!ent_valid[i]) begin
        free_idx = ADDR_W'(i);
      end
    end
  end

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = MR_N && out_free && !(in_mf && !hit && cam_full);
  assign accept    = in_valid && in_ready;
  assign do_hit    = accept && in_mf && hit;
  assign do_miss   = accept && in_mf && !hit;
  assign do_bypass = accept && !in_mf;
  assign hit_data  = ent_data[hit_idx];

  always_comb begin
    valid_nxt = ent_valid;
    if (do_miss) valid_nxt[free_idx] = 1'b1;
    if (do_hit)  valid_nxt[hit_idx]  = 1'b0;
  end

  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      ent_valid <= '0;
      cam_full  <= 1'b0;
      cam_wr    <= 1'b0;
      cam_del   <= 1'b0;
      cam_addr  <= '0;
    end else begin
      ent_valid <= valid_nxt;
      cam_full  <= &valid_nxt;
      cam_wr    <= do_miss;
      cam_del   <= do_hit;
      if (do_miss)     cam_addr <= free_idx;
      else if (do_hit) cam_addr <= hit_idx;
    end
  end

  // Payload storage needs no reset: an entry is meaningless until its valid bit is set.
  always_ff @(posedge CP) begin
    if (do_miss) begin
      ent_key[free_idx]  <= in_key;
      ent_lr[free_idx]   <= in_lr;
      ent_data[free_idx] <= in_data;
    end
  end

  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      out_valid  <= 1'b0;
      out_key    <= '0;
      out_fire   <= 1'b0;
      out_data_l <= '0;
      out_data_r <= '0;
    end else if (out_free) begin
      out_valid <= do_hit || do_bypass;
      if (do_bypass) begin
        out_key    <= in_key;
        out_fire   <= 1'b0;
        out_data_l <= in_data;
        out_data_r <= '0;
      end else if (do_hit) begin
        out_key    <= in_key;
        out_fire   <= 1'b1;
        out_data_l <= in_lr ? hit_data : in_data;
        out_data_r <= in_lr ? in_data  : hit_data;
      end
    end
  end

`ifdef MMCAM_STATS_EN
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      occ     <= '0;
      occ_max <= '0;
    end else if (do_miss) begin
      occ <= occ + 1'b1;
      if ((occ + 1'b1) > occ_max) occ_max <= occ + 1'b1;
    end else if (do_hit) begin
      occ <= occ - 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire
